// File: rtl/usr_pkg.sv
// Shared types for the universal shift register.
//   mode_t  : 3-bit command code (HOLD, LOAD, SHL, SHR, ASR, ROL, ROR, reserved)
//   state_t : burst FSM state (IDLE, SHIFT)
//   is_step_mode() : true for codes that perform shift/rotate steps.
// Optional feature macro: USR_ROTATE_EN (enables ROL/ROR; otherwise they act as HOLD).
package usr_pkg;

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_LOAD = 3'b001,
    M_SHL  = 3'b010,
    M_SHR  = 3'b011,
    M_ASR  = 3'b100,
    M_ROL  = 3'b101,
    M_ROR  = 3'b110,
    M_RSVD = 3'b111
  } mode_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  function automatic logic is_step_mode(input mode_t m);
    logic r;
    r = 1'b0;
    case (m)
      M_SHL, M_SHR, M_ASR: r = 1'b1;
`ifdef USR_ROTATE_EN
      M_ROL, M_ROR:        r = 1'b1;
`endif
      default:             r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/usr_step.sv
// Combinational single-step next-value logic for the universal shift register.
// Ports:
//   q         in  WIDTH  current register contents
//   mode      in  mode_t operation to apply
//   sin_l     in  1      serial bit entering the MSB on SHR
//   sin_r     in  1      serial bit entering the LSB on SHL
//   q_next    out WIDTH  register value after one step
//   sout_next out 1      bit shifted/rotated out by this step
// Non-step modes pass q through; sout_next is then don't-care (the top only
// commits it on real steps).
// Optional feature macro: USR_ROTATE_EN (ROL/ROR datapath present only when defined).
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  mode_t            mode,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q_next,
  output logic             sout_next
);

  always_comb begin
    q_next    = q;
    sout_next = 1'b0;
    case (mode)
      M_SHL: begin
        q_next    = {q[WIDTH-2:0], sin_r};
        sout_next = q[WIDTH-1];
      end
      M_SHR: begin
        q_next    = {sin_l, q[WIDTH-1:1]};
        sout_next = q[0];
      end
      M_ASR: begin
        q_next    = {q[WIDTH-1], q[WIDTH-1:1]};
        sout_next = q[0];
      end
`ifdef USR_ROTATE_EN
      M_ROL: begin
        q_next    = {q[WIDTH-2:0], q[WIDTH-1]};
        sout_next = q[WIDTH-1];
      end
      M_ROR: begin
        q_next    = {q[0], q[WIDTH-1:1]};
        sout_next = q[0];
      end
`endif
      default: begin
        q_next    = q;
        sout_next = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register with parallel load, shift/rotate modes and
// multi-cycle burst shifts under a busy/done handshake.
// Ports:
//   clk     in  1      clock, all state on posedge
//   reset   in  1      synchronous active-high reset
//   start   in  1      command strobe, accepted only while busy=0
//   mode    in  3      command code (see usr_pkg::mode_t)
//   amount  in  CNT_W  number of single-bit steps for shift/rotate
//   d       in  WIDTH  parallel load data
//   sin_l   in  1      serial input at MSB for SHR
//   sin_r   in  1      serial input at LSB for SHL
//   q       out WIDTH  register contents
//   sout    out 1      last bit shifted/rotated out
//   busy    out 1      burst in progress
//   done    out 1      one-cycle completion pulse
// Optional feature macro: USR_ROTATE_EN (ROL/ROR; otherwise those codes act as HOLD).
module universal_shift_register
  import usr_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  state_t           state, state_nxt;
  mode_t            mode_lat;
  mode_t            cmd_mode;
  mode_t            step_mode;
  logic [CNT_W-1:0] rem, rem_nxt;
  logic             load_en, step_en, latch_en, done_nxt;
  logic [WIDTH-1:0] q_step;
  logic             sout_step;

  assign cmd_mode = mode_t'(mode);
  // During a burst the latched mode drives the step logic; the live mode
  // input is ignored until the FSM returns to IDLE.
  assign step_mode = (state == S_SHIFT) ? mode_lat : cmd_mode;
  assign busy      = (state == S_SHIFT);

  usr_step #(.WIDTH(WIDTH)) u_step (
    .q         (q),
    .mode      (step_mode),
    .sin_l     (sin_l),
    .sin_r     (sin_r),
    .q_next    (q_step),
    .sout_next (sout_step)
  );

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    load_en   = 1'b0;
    step_en   = 1'b0;
    latch_en  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (cmd_mode == M_LOAD) begin
            load_en  = 1'b1;
            done_nxt = 1'b1;
          end else if (is_step_mode(cmd_mode) && (amount != '0)) begin
            // First step happens on the accepting edge, so only k-1 remain.
            step_en  = 1'b1;
            latch_en = 1'b1;
            rem_nxt  = amount - CNT_W'(1);
            if (amount == CNT_W'(1)) done_nxt  = 1'b1;
            else                     state_nxt = S_SHIFT;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        step_en = 1'b1;
        rem_nxt = rem - CNT_W'(1);
        if (rem == CNT_W'(1)) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      rem      <= '0;
      mode_lat <= M_HOLD;
      q        <= '0;
      sout     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      done  <= done_nxt;
      if (latch_en) mode_lat <= cmd_mode;
      if (load_en) begin
        q <= d;
      end else if (step_en) begin
        q    <= q_step;
        sout <= sout_step;
      end
    end
  end

endmodule
